nasti_stream_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter: merges N_SRC NASTI-stream sources onto one stream sink.
//  The sink is typically the input of a stream buffer or a DMA write path.

---
 rtl/nasti_stream_arb_pkg.sv | 18 +
 rtl/nasti_stream_rr_pick.sv | 47 ++++
 rtl/nasti_stream_arbiter.sv | 129 ++++++++++++
 tb/tb_nasti_stream_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nasti_stream_arb_pkg.sv
// Shared state type and pointer helpers for the NASTI-stream packet arbiter.
package nasti_stream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Round-robin successor of ptr within 0..n-1.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/nasti_stream_rr_pick.sv
// Combinational priority rotator: first asserted request at or after ptr, wrapping modulo N_SRC.
module nasti_stream_rr_pick
  import nasti_stream_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W:0] N_SRC_W = (IDX_W + 1)'(N_SRC);

  logic [2*N_SRC-1:0] req_dbl;
  logic [N_SRC-1:0]   req_rot;
  logic [IDX_W-1:0]   offset;
  logic               found;
  logic [IDX_W:0]     idx_sum;

  // Rotating a doubled copy puts request ptr at bit 0, so the lowest set bit is the winner.
  assign req_dbl = {req, req};
  assign req_rot = N_SRC'(req_dbl >> ptr);
  assign any     = |req;

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = IDX_W'(k);
      end
    end
  end

  always_comb begin
    idx_sum = {1'b0, ptr} + {1'b0, offset};
    if (idx_sum >= N_SRC_W) begin
      idx = IDX_W'(idx_sum - N_SRC_W);
    end else begin
      idx = IDX_W'(idx_sum);
    end
  end

endmodule

// File: rtl/nasti_stream_arbiter.sv
// Packet-granular round-robin arbiter merging N_SRC NASTI-stream sources onto one sink.
// Define NASTI_STREAM_ARB_ID_TAG_EN to replace dest t_id with the granted source index.
module nasti_stream_arbiter
  import nasti_stream_arb_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [N_SRC-1:0]                       src_t_valid,
  output logic [N_SRC-1:0]                       src_t_ready,
  input  logic [N_SRC-1:0][DATA_WIDTH-1:0]       src_t_data,
  input  logic [N_SRC-1:0][DATA_WIDTH/8-1:0]     src_t_strb,
  input  logic [N_SRC-1:0][DATA_WIDTH/8-1:0]     src_t_keep,
  input  logic [N_SRC-1:0]                       src_t_last,
  input  logic [N_SRC-1:0][ID_WIDTH-1:0]         src_t_id,
  input  logic [N_SRC-1:0][DEST_WIDTH-1:0]       src_t_dest,
  input  logic [N_SRC-1:0][USER_WIDTH-1:0]       src_t_user,
  output logic                                   dest_t_valid,
  input  logic                                   dest_t_ready,
  output logic [DATA_WIDTH-1:0]                  dest_t_data,
  output logic [DATA_WIDTH/8-1:0]                dest_t_strb,
  output logic [DATA_WIDTH/8-1:0]                dest_t_keep,
  output logic                                   dest_t_last,
  output logic [ID_WIDTH-1:0]                    dest_t_id,
  output logic [DEST_WIDTH-1:0]                  dest_t_dest,
  output logic [USER_WIDTH-1:0]                  dest_t_user,
  output logic [N_SRC-1:0]                       grant,
  output logic                                   busy
);

  localparam int               IDX_W     = idx_width(N_SRC);
  localparam logic [N_SRC-1:0] GRANT_LSB = N_SRC'(1);

  if (N_SRC < 2) begin : g_n_src_check
    $error("nasti_stream_arbiter needs at least two sources");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             fire;

  nasti_stream_rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (src_t_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Grant is taken in IDLE without moving a beat; it is released only by an accepted t_last.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    fire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_idx_d = pick_idx;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        fire = src_t_valid[gnt_idx_q] && dest_t_ready;
        if (fire && src_t_last[gnt_idx_q]) begin
          state_d  = IDLE;
          rr_ptr_d = IDX_W'(rr_next(32'(gnt_idx_q), N_SRC));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == BUSY);
    grant       = '0;
    src_t_ready = '0;
    if (busy) begin
      grant = GRANT_LSB << gnt_idx_q;
      if (dest_t_ready) begin
        src_t_ready = grant;
      end
    end
    dest_t_valid = busy && src_t_valid[gnt_idx_q];
    dest_t_data  = src_t_data[gnt_idx_q];
    dest_t_strb  = src_t_strb[gnt_idx_q];
    dest_t_keep  = src_t_keep[gnt_idx_q];
    dest_t_last  = src_t_last[gnt_idx_q];
    dest_t_dest  = src_t_dest[gnt_idx_q];
    dest_t_user  = src_t_user[gnt_idx_q];
`ifdef NASTI_STREAM_ARB_ID_TAG_EN
    dest_t_id    = ID_WIDTH'(gnt_idx_q);
`else
    dest_t_id    = src_t_id[gnt_idx_q];
`endif
  end

`ifdef NASTI_STREAM_ARB_ID_TAG_EN
  if (ID_WIDTH < IDX_W) begin : g_id_width_check
    $error("ID_WIDTH too narrow to carry the source index tag");
  end

  logic unused_src_id;
  assign unused_src_id = ^src_t_id;
`endif

endmodule

// File: tb/tb_nasti_stream_arbiter.sv
// Scoreboard bench for nasti_stream_arbiter: a packet-level round-robin model predicts the merged beat stream.
// Honours NASTI_STREAM_ARB_ID_TAG_EN (ID_WIDTH=2 and source-index t_id expected when defined).
module tb_nasti_stream_arbiter;

  localparam int N_SRC = 4;
`ifdef NASTI_STREAM_ARB_ID_TAG_EN
  localparam int ID_W = 2;
`else
  localparam int ID_W = 1;
`endif

  typedef struct {
    int              src;
    bit              first;
    logic [63:0]     data;
    logic [7:0]      strb;
    logic [7:0]      keep;
    logic            last;
    logic [ID_W-1:0] id;
    logic            dest;
    logic            user;
  } beat_t;

  logic                         aclk;
  logic                         areset;
  logic [N_SRC-1:0]             src_t_valid;
  logic [N_SRC-1:0]             src_t_ready;
  logic [N_SRC-1:0][63:0]       src_t_data;
  logic [N_SRC-1:0][7:0]        src_t_strb;
  logic [N_SRC-1:0][7:0]        src_t_keep;
  logic [N_SRC-1:0]             src_t_last;
  logic [N_SRC-1:0][ID_W-1:0]   src_t_id;
  logic [N_SRC-1:0][0:0]        src_t_dest;
  logic [N_SRC-1:0][0:0]        src_t_user;
  logic                         dest_t_valid;
  logic                         dest_t_ready;
  logic [63:0]                  dest_t_data;
  logic [7:0]                   dest_t_strb;
  logic [7:0]                   dest_t_keep;
  logic                         dest_t_last;
  logic [ID_W-1:0]              dest_t_id;
  logic [0:0]                   dest_t_dest;
  logic [0:0]                   dest_t_user;
  logic [N_SRC-1:0]             grant;
  logic                         busy;

  beat_t src_q[N_SRC][$];
  int    pkt_len_q[N_SRC][$];
  beat_t exp_q[$];
  int    exp_cycles;
  bit    mon_en;
  int    tests_run;
  int    tests_failed;

  nasti_stream_arbiter #(
    .N_SRC      (N_SRC),
    .ID_WIDTH   (ID_W),
    .DEST_WIDTH (1),
    .USER_WIDTH (1),
    .DATA_WIDTH (64)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .src_t_valid  (src_t_valid),
    .src_t_ready  (src_t_ready),
    .src_t_data   (src_t_data),
    .src_t_strb   (src_t_strb),
    .src_t_keep   (src_t_keep),
    .src_t_last   (src_t_last),
    .src_t_id     (src_t_id),
    .src_t_dest   (src_t_dest),
    .src_t_user   (src_t_user),
    .dest_t_valid (dest_t_valid),
    .dest_t_ready (dest_t_ready),
    .dest_t_data  (dest_t_data),
    .dest_t_strb  (dest_t_strb),
    .dest_t_keep  (dest_t_keep),
    .dest_t_last  (dest_t_last),
    .dest_t_id    (dest_t_id),
    .dest_t_dest  (dest_t_dest),
    .dest_t_user  (dest_t_user),
    .grant        (grant),
    .busy         (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output beat.
  always @(negedge aclk) begin
    if (mon_en && !areset) begin
      check_output("ready_without_grant", 64'(src_t_ready & ~grant), 64'd0);
      check_output("valid_while_idle", 64'(dest_t_valid & ~busy), 64'd0);
      if (dest_t_valid && dest_t_ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_beat: got data %0h, expected no beat", dest_t_data);
        end else begin
          beat_t e;
          logic [N_SRC-1:0] exp_grant;
          logic [ID_W-1:0]  exp_id;
          e = exp_q.pop_front();
          exp_grant = N_SRC'(1) << e.src;
`ifdef NASTI_STREAM_ARB_ID_TAG_EN
          exp_id = ID_W'(e.src);
`else
          exp_id = e.id;
`endif
          check_output("data", dest_t_data, e.data);
          check_output("strb", 64'(dest_t_strb), 64'(e.strb));
          check_output("keep", 64'(dest_t_keep), 64'(e.keep));
          check_output("last", 64'(dest_t_last), 64'(e.last));
          check_output("id", 64'(dest_t_id), 64'(exp_id));
          check_output("dest", 64'(dest_t_dest), 64'(e.dest));
          check_output("user", 64'(dest_t_user), 64'(e.user));
          check_output("grant", 64'(grant), 64'(exp_grant));
        end
      end
    end
  end

  task automatic add_packet(input int s, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.src   = s;
      b.first = (j == 0);
      b.data  = {$urandom, $urandom};
      b.strb  = 8'($urandom);
      b.keep  = 8'($urandom);
      b.last  = (j == len - 1);
      b.id    = ID_W'($urandom);
      b.dest  = 1'($urandom);
      b.user  = 1'($urandom);
      src_q[s].push_back(b);
    end
    pkt_len_q[s].push_back(len);
  endtask

  // Reference model: every source with packets left is requesting at each arbitration,
  // so whole packets leave in round-robin order starting at source 0, each costing len+1 cycles.
  task automatic build_expected();
    int pk[N_SRC];
    int cur[N_SRC];
    int ptr;
    int pick;
    int len;
    ptr = 0;
    exp_cycles = 0;
    for (int s = 0; s < N_SRC; s++) begin
      pk[s] = 0;
      cur[s] = 0;
    end
    forever begin
      pick = -1;
      for (int k = 0; k < N_SRC; k++) begin
        int s;
        s = (ptr + k) % N_SRC;
        if (pick < 0 && pk[s] < pkt_len_q[s].size()) pick = s;
      end
      if (pick < 0) break;
      len = pkt_len_q[pick][pk[pick]];
      for (int j = 0; j < len; j++) exp_q.push_back(src_q[pick][cur[pick] + j]);
      cur[pick] += len;
      pk[pick]++;
      exp_cycles += len + 1;
      ptr = (pick + 1) % N_SRC;
    end
  endtask

  task automatic drive_sources(input int gap_pct);
    beat_t b;
    for (int s = 0; s < N_SRC; s++) begin
      if (src_q[s].size() == 0) begin
        src_t_valid[s] = 1'b0;
      end else begin
        b = src_q[s][0];
        if (!b.first && ($urandom_range(99) < gap_pct)) begin
          src_t_valid[s] = 1'b0;
        end else begin
          src_t_valid[s] = 1'b1;
          src_t_data[s]  = b.data;
          src_t_strb[s]  = b.strb;
          src_t_keep[s]  = b.keep;
          src_t_last[s]  = b.last;
          src_t_id[s]    = b.id;
          src_t_dest[s]  = b.dest;
          src_t_user[s]  = b.user;
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge aclk);
    #1;
    areset       = 1'b1;
    src_t_valid  = '0;
    dest_t_ready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  // Resets the DUT, then streams every queued packet until all beats are accepted.
  task automatic apply_stimulus(input int gap_pct, input int ready_pct, output int cycles);
    bit fired[N_SRC];
    int remaining;
    build_expected();
    apply_reset();
    remaining = 0;
    for (int s = 0; s < N_SRC; s++) remaining += src_q[s].size();
    drive_sources(gap_pct);
    dest_t_ready = ($urandom_range(99) < ready_pct);
    cycles = 0;
    while (remaining > 0 && cycles < 5000) begin
      @(negedge aclk);
      for (int s = 0; s < N_SRC; s++) fired[s] = src_t_valid[s] && src_t_ready[s];
      @(posedge aclk);
      cycles++;
      #1;
      for (int s = 0; s < N_SRC; s++) begin
        if (fired[s]) begin
          void'(src_q[s].pop_front());
          remaining--;
        end
      end
      drive_sources(gap_pct);
      dest_t_ready = ($urandom_range(99) < ready_pct);
    end
    if (remaining > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL traffic_timeout: got %0d beats left, expected 0", remaining);
      for (int s = 0; s < N_SRC; s++) src_q[s].delete();
    end
    src_t_valid  = '0;
    dest_t_ready = 1'b1;
    repeat (3) @(posedge aclk);
    check_output("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    for (int s = 0; s < N_SRC; s++) pkt_len_q[s].delete();
  endtask

  initial begin
    int cycles;
    tests_run    = 0;
    tests_failed = 0;
    mon_en       = 1'b1;
    areset       = 1'b1;
    dest_t_ready = 1'b1;
    src_t_valid  = '1;
    src_t_data   = '0;
    src_t_strb   = '0;
    src_t_keep   = '0;
    src_t_last   = '0;
    src_t_id     = '0;
    src_t_dest   = '0;
    src_t_user   = '0;

    // Reset held two cycles with every source requesting.
    repeat (2) begin
      @(posedge aclk);
      @(negedge aclk);
      check_output("reset_dest_valid", 64'(dest_t_valid), 64'd0);
      check_output("reset_grant", 64'(grant), 64'd0);
      check_output("reset_busy", 64'(busy), 64'd0);
      check_output("reset_src_ready", 64'(src_t_ready), 64'd0);
    end

    // Round-robin: two 2-beat packets per source, continuous ready.
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N_SRC; s++) add_packet(s, 2);
    apply_stimulus(0, 100, cycles);
    check_output("rr_cycles", 64'(cycles), 64'(exp_cycles));

    // No interleave: a 4-beat packet from src0 competes with src1.
    add_packet(0, 4);
    add_packet(1, 2);
    apply_stimulus(0, 100, cycles);
    check_output("no_interleave_cycles", 64'(cycles), 64'(exp_cycles));

    // Backpressure and mid-packet valid gaps on src2.
    add_packet(2, 5);
    add_packet(2, 3);
    add_packet(0, 1);
    apply_stimulus(40, 50, cycles);

    // Randomized mixes.
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < N_SRC; s++) begin
        int n;
        n = $urandom_range(3);
        for (int p = 0; p < n; p++) add_packet(s, 1 + $urandom_range(5));
      end
      apply_stimulus(int'($urandom_range(40)), 40 + int'($urandom_range(60)), cycles);
    end

    // Mid-packet reset: leave rr_ptr at 3, abandon a src1 packet, then expect arbitration from 0.
    mon_en = 1'b0;
    apply_reset();
    src_t_valid[2] = 1'b1;
    src_t_last[2]  = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    src_t_valid[2] = 1'b0;
    src_t_last[2]  = 1'b0;
    src_t_valid[1] = 1'b1;
    src_t_last[1]  = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_output("midreset_grant_before", 64'(grant), 64'(4'b0010));
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    src_t_valid[1] = 1'b0;
    src_t_valid[0] = 1'b1;
    src_t_valid[3] = 1'b1;
    src_t_last[0]  = 1'b1;
    src_t_last[3]  = 1'b1;
    @(negedge aclk);
    check_output("midreset_busy", 64'(busy), 64'd0);
    check_output("midreset_grant_idle", 64'(grant), 64'd0);
    @(posedge aclk);
    @(negedge aclk);
    check_output("midreset_ptr_zero", 64'(grant), 64'(4'b0001));
    src_t_valid = '0;
    repeat (4) @(posedge aclk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
